// File: rtl/dma_host_bus_agent.sv
// Host-side bus agent for the DMA controller: runs CPU register accesses over
// CS_N/IOR_N/IOW_N/A/DB and answers HRQ with HLDA, releasing the bus while held.
module dma_host_bus_agent #(
    parameter int unsigned DATAWIDTH     = 8,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_DELAY    = 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [3:0]           cmd_addr,
    input  logic [DATAWIDTH-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic [DATAWIDTH-1:0] rsp_rdata,
    input  logic                 HRQ,
    output logic                 HLDA,
    output logic                 CS_N,
    output logic                 ior_n_out,
    output logic                 iow_n_out,
    output logic                 io_oe,
    output logic [3:0]           addr_out,
    output logic                 addr_oe,
    output logic [DATAWIDTH-1:0] db_out,
    output logic                 db_oe,
    input  logic [DATAWIDTH-1:0] db_in
);

    localparam int unsigned MaxCnt = (STROBE_CYCLES > HOLD_DELAY) ? STROBE_CYCLES : HOLD_DELAY;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);
    localparam logic [CntW-1:0] StrobeLast = CntW'(STROBE_CYCLES - 1);
    localparam logic [CntW-1:0] HoldLast   = CntW'(HOLD_DELAY - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StRecover,
        StHoldWait,
        StHold
    } state_e;

    state_e                 state_q;
    logic [CntW-1:0]        cnt_q;
    logic                   write_q;
    logic                   rsp_valid_q;
    logic [DATAWIDTH-1:0]   rsp_rdata_q;
    logic                   hlda_q;
    logic                   cs_n_q;
    logic                   ior_n_q;
    logic                   iow_n_q;
    logic                   io_oe_q;
    logic [3:0]             addr_q;
    logic                   addr_oe_q;
    logic [DATAWIDTH-1:0]   db_out_q;
    logic                   db_oe_q;

    // HRQ wins over a simultaneous command, so ready drops as soon as HRQ is seen.
    assign cmd_ready = (state_q == StIdle) && !HRQ && !RESET;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            hlda_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            ior_n_q     <= 1'b1;
            iow_n_q     <= 1'b1;
            io_oe_q     <= 1'b1;
            addr_q      <= '0;
            addr_oe_q   <= 1'b1;
            db_out_q    <= '0;
            db_oe_q     <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (HRQ) begin
                        state_q <= StHoldWait;
                        cnt_q   <= '0;
                    end else if (cmd_valid) begin
                        state_q   <= StSetup;
                        write_q   <= cmd_write;
                        cs_n_q    <= 1'b0;
                        addr_q    <= cmd_addr;
                        addr_oe_q <= 1'b1;
                        if (cmd_write) begin
                            db_out_q <= cmd_wdata;
                            db_oe_q  <= 1'b1;
                        end
                    end
                end
                StSetup: begin
                    state_q <= StStrobe;
                    cnt_q   <= '0;
                    if (write_q) begin
                        iow_n_q <= 1'b0;
                    end else begin
                        ior_n_q <= 1'b0;
                    end
                end
                StStrobe: begin
                    if (cnt_q == StrobeLast) begin
                        state_q     <= StRecover;
                        ior_n_q     <= 1'b1;
                        iow_n_q     <= 1'b1;
                        cs_n_q      <= 1'b1;
                        db_oe_q     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        if (!write_q) begin
                            rsp_rdata_q <= db_in;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StRecover: begin
                    state_q <= StIdle;
                end
                StHoldWait: begin
                    if (!HRQ) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else if (cnt_q == HoldLast) begin
                        // Grant and float all bus drivers in the same edge.
                        state_q   <= StHold;
                        hlda_q    <= 1'b1;
                        io_oe_q   <= 1'b0;
                        addr_oe_q <= 1'b0;
                        db_oe_q   <= 1'b0;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StHold: begin
                    if (!HRQ) begin
                        state_q   <= StIdle;
                        hlda_q    <= 1'b0;
                        io_oe_q   <= 1'b1;
                        addr_oe_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign HLDA      = hlda_q;
    assign CS_N      = cs_n_q;
    assign ior_n_out = ior_n_q;
    assign iow_n_out = iow_n_q;
    assign io_oe     = io_oe_q;
    assign addr_out  = addr_q;
    assign addr_oe   = addr_oe_q;
    assign db_out    = db_out_q;
    assign db_oe     = db_oe_q;

endmodule
